// File: rtl/data_mem_sp_gen_if.sv
// rtl/data_mem_sp_gen_if.sv - access/clear bus of the single-port data memory
interface data_mem_sp_gen_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                    ce;
    logic                    oce;
    logic                    wre;
    logic [ADDR_WIDTH-1:0]   ad;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   din;
    logic                    clr;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    busy;
    logic                    clr_done;

    modport master (
        output ce, oce, wre, ad, be, din, clr,
        input  dout, busy, clr_done
    );

    modport slave (
        input  ce, oce, wre, ad, be, din, clr,
        output dout, busy, clr_done
    );
endinterface

// File: rtl/data_mem_sp_gen.sv
// rtl/data_mem_sp_gen.sv - single-port byte-enabled RAM with zero-fill engine
module data_mem_sp_gen #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int OUT_REG        = 0,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_sp_gen_if.slave   bus
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_done_q, clr_done_d;
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word, wt_word;
    logic                  acc_en, clr_wr;

    // clr wins over a same-cycle access; nothing is accepted during a clear
    assign acc_en = bus.ce && (state_q == IDLE) && !reset && !bus.clr;
    assign clr_wr = (state_q == CLEAR) && !reset;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        rd_word = mem[bus.ad];
        wt_word = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.be[i]) wt_word[8*i +: 8] = bus.din[8*i +: 8];
        end
    end

    // Memory array has no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q] <= '0;
        end else if (acc_en && bus.wre) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) mem[bus.ad][8*i +: 8] <= bus.din[8*i +: 8];
            end
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (acc_en) begin
            if (!bus.wre)            s1_d = rd_word;
            else if (READ_MODE == 1) s1_d = wt_word;
            else if (READ_MODE == 2) s1_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s1_q <= '0;
        else       s1_q <= s1_d;
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] s2_q;
        always_ff @(posedge clk) begin
            if (reset)        s2_q <= '0;
            else if (bus.oce) s2_q <= s1_q;
        end
        assign bus.dout = s2_q;
    end else begin : g_noreg
        assign bus.dout = s1_q;
    end

    assign bus.busy     = (state_q == CLEAR);
    assign bus.clr_done = clr_done_q;
endmodule
